// File: rtl/mxint8_block_sequencer_if.sv
// Block-in / element-issue / result-return / block-out bundle for the MXINT8 block sequencer.
// slave is the sequencer's view; master is the environment driving it.
interface mxint8_block_sequencer_if #(
  parameter int unsigned BLOCK_SIZE  = 32,
  parameter int unsigned ELEM_WIDTH  = 8,
  parameter int unsigned SCALE_WIDTH = 8
);
  localparam int unsigned IDX_W = $clog2(BLOCK_SIZE);

  logic                                   in_valid;
  logic                                   in_ready;
  logic [0:BLOCK_SIZE-1][ELEM_WIDTH-1:0]  in_elements;
  logic [SCALE_WIDTH-1:0]                 in_scale;

  logic                                   elem_valid;
  logic                                   elem_ready;
  logic [ELEM_WIDTH-1:0]                  elem_data;
  logic [IDX_W-1:0]                       elem_idx;

  logic                                   res_valid;
  logic [ELEM_WIDTH-1:0]                  res_data;

  logic                                   out_valid;
  logic                                   out_ready;
  logic [0:BLOCK_SIZE-1][ELEM_WIDTH-1:0]  out_elements;
  logic [SCALE_WIDTH-1:0]                 out_scale;

  logic                                   err_spurious;

  modport slave (
    input  in_valid, in_elements, in_scale, elem_ready, res_valid, res_data, out_ready,
    output in_ready, elem_valid, elem_data, elem_idx, out_valid, out_elements, out_scale,
    output err_spurious
  );

  modport master (
    output in_valid, in_elements, in_scale, elem_ready, res_valid, res_data, out_ready,
    input  in_ready, elem_valid, elem_data, elem_idx, out_valid, out_elements, out_scale,
    input  err_spurious
  );
endinterface

// File: rtl/mxint8_block_sequencer.sv
// Sequences one MXINT8 block through a scalar element unit: captures the block, issues
// elements in order, gathers in-order results and presents the rebuilt block with its scale.
module mxint8_block_sequencer #(
  parameter int unsigned BLOCK_SIZE  = 32,
  parameter int unsigned ELEM_WIDTH  = 8,
  parameter int unsigned SCALE_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  mxint8_block_sequencer_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(BLOCK_SIZE);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_SIZE - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BLOCK_SIZE);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e                                state_q;
  logic [CNT_W-1:0]                      issue_cnt_q;
  logic [CNT_W-1:0]                      ret_cnt_q;
  logic [0:BLOCK_SIZE-1][ELEM_WIDTH-1:0] in_elems_q;
  logic [0:BLOCK_SIZE-1][ELEM_WIDTH-1:0] out_elems_q;
  logic [SCALE_WIDTH-1:0]                scale_q;
  logic                                  elem_valid_q;
  logic                                  out_valid_q;
  logic                                  err_q;

  logic issue_hs;
  logic ret_ok;
  logic last_ret;

  assign issue_hs = elem_valid_q && bus.elem_ready;
  // Results count only while a block is in flight and not yet fully returned.
  assign ret_ok   = bus.res_valid && ((state_q == StIssue) || (state_q == StDrain)) &&
                    (ret_cnt_q < FULL_CNT);
  assign last_ret = ret_ok && (ret_cnt_q == LAST_CNT);

  assign bus.in_ready     = (state_q == StIdle) && !rst;
  assign bus.elem_valid   = elem_valid_q;
  assign bus.elem_data    = in_elems_q[issue_cnt_q[IDX_W-1:0]];
  assign bus.elem_idx     = issue_cnt_q[IDX_W-1:0];
  assign bus.out_valid    = out_valid_q;
  assign bus.out_elements = out_elems_q;
  assign bus.out_scale    = scale_q;
  assign bus.err_spurious = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      issue_cnt_q  <= '0;
      ret_cnt_q    <= '0;
      in_elems_q   <= '0;
      out_elems_q  <= '0;
      scale_q      <= '0;
      elem_valid_q <= 1'b0;
      out_valid_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (bus.res_valid) begin
        if (ret_ok) begin
          out_elems_q[ret_cnt_q[IDX_W-1:0]] <= bus.res_data;
          ret_cnt_q                         <= ret_cnt_q + CNT_W'(1);
        end else begin
          err_q <= 1'b1;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            in_elems_q   <= bus.in_elements;
            scale_q      <= bus.in_scale;
            elem_valid_q <= 1'b1;
            state_q      <= StIssue;
          end
        end
        StIssue: begin
          // The index holds at the last element so it never wraps.
          if (issue_hs && (issue_cnt_q != LAST_CNT)) begin
            issue_cnt_q <= issue_cnt_q + CNT_W'(1);
          end
          if (last_ret) begin
            elem_valid_q <= 1'b0;
            out_valid_q  <= 1'b1;
            state_q      <= StDone;
          end else if (issue_hs && (issue_cnt_q == LAST_CNT)) begin
            elem_valid_q <= 1'b0;
            state_q      <= StDrain;
          end
        end
        StDrain: begin
          if (last_ret) begin
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_mxint8_block_sequencer.sv
// Randomised scoreboard bench for mxint8_block_sequencer with a modelled negate unit.
module tb_mxint8_block_sequencer;
  localparam int BS = 4;
  localparam int EW = 8;
  localparam int SW = 8;

  typedef logic [0:BS-1][EW-1:0] blk_el_t;
  typedef struct {
    blk_el_t         el;
    logic [SW-1:0]   sc;
  } blk_t;
  typedef struct {
    logic [EW-1:0] d;
    int            due;
  } unit_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mxint8_block_sequencer_if #(.BLOCK_SIZE(BS), .ELEM_WIDTH(EW), .SCALE_WIDTH(SW)) bus ();

  mxint8_block_sequencer #(.BLOCK_SIZE(BS), .ELEM_WIDTH(EW), .SCALE_WIDTH(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  blk_t    exp_q[$];
  blk_el_t iss_q[$];
  unit_t   unit_q[$];
  int      idx_log[$];

  int unit_lat     = 2;
  bit spur_req     = 1'b0;
  int ready_mode   = 0;
  bit out_rdy_rand = 1'b0;
  bit out_rdy_hold = 1'b1;
  bit log_idx      = 1'b0;
  int xfer_cnt     = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: each element is replaced by its additive inverse modulo 2^EW.
  function automatic logic [EW-1:0] neg_elem(input logic [EW-1:0] x);
    return EW'((1 << EW) - int'(x));
  endfunction

  function automatic blk_el_t ref_block(input blk_el_t e);
    blk_el_t r;
    for (int i = 0; i < BS; i++) r[i] = neg_elem(e[i]);
    return r;
  endfunction

  function automatic blk_el_t rand_block(input bit nonzero);
    blk_el_t r;
    for (int i = 0; i < BS; i++) begin
      r[i] = nonzero ? EW'($urandom_range(1, 255)) : EW'($urandom);
    end
    return r;
  endfunction

  // Negate unit: fixed latency, in order, no backpressure.
  initial begin
    bus.res_valid = 1'b0;
    bus.res_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.res_valid = 1'b0;
      if (spur_req) begin
        bus.res_valid = 1'b1;
        bus.res_data  = 8'hA5;
        spur_req      = 1'b0;
      end else if (unit_q.size() > 0 && unit_q[0].due <= cyc) begin
        bus.res_valid = 1'b1;
        bus.res_data  = unit_q[0].d;
        void'(unit_q.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.elem_valid && bus.elem_ready) begin
        unit_q.push_back('{d: neg_elem(bus.elem_data), due: cyc + unit_lat});
      end
    end
  end

  initial begin
    bus.elem_ready = 1'b1;
    bus.out_ready  = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.elem_ready = 1'b1;
        1:       bus.elem_ready = bus.elem_valid ? !bus.elem_ready : 1'b1;
        default: bus.elem_ready = 1'($urandom_range(0, 1));
      endcase
      bus.out_ready = out_rdy_rand ? 1'($urandom_range(0, 1)) : out_rdy_hold;
    end
  end

  // Issue-side monitor.
  initial begin
    int            iss_n = 0;
    bit            stalled = 1'b0;
    logic [EW-1:0] held_d = '0;
    logic [1:0]    held_i = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        iss_n   = 0;
        stalled = 1'b0;
      end else if (bus.elem_valid) begin
        if (log_idx) idx_log.push_back(int'(bus.elem_idx));
        chk("in_ready_while_issuing", bus.in_ready, 0);
        if (iss_q.size() == 0) begin
          chk("issue_without_block", 1, 0);
        end else begin
          chk("elem_idx", bus.elem_idx, iss_n);
          chk("elem_data", bus.elem_data, iss_q[0][iss_n]);
        end
        if (stalled) chk("stall_hold", {held_i, held_d}, {bus.elem_idx, bus.elem_data});
        stalled = !bus.elem_ready;
        held_i  = bus.elem_idx;
        held_d  = bus.elem_data;
        if (bus.elem_ready) begin
          iss_n++;
          if (iss_n == BS) begin
            iss_n = 0;
            if (iss_q.size() > 0) void'(iss_q.pop_front());
          end
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  // Output-side scoreboard monitor.
  initial begin
    blk_t held;
    blk_t e;
    bit   hold_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_v = 1'b0;
      end else if (bus.out_valid) begin
        chk("in_ready_while_done", bus.in_ready, 0);
        if (hold_v) begin
          chk("out_elements_hold", bus.out_elements, held.el);
          chk("out_scale_hold", bus.out_scale, held.sc);
        end
        if (bus.out_ready) begin
          xfer_cnt++;
          hold_v = 1'b0;
          if (exp_q.size() == 0) begin
            chk("unexpected_out", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("out_elements", bus.out_elements, e.el);
            chk("out_scale", bus.out_scale, e.sc);
          end
        end else begin
          hold_v  = 1'b1;
          held.el = bus.out_elements;
          held.sc = bus.out_scale;
        end
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  task automatic send_block(input blk_el_t el, input logic [SW-1:0] sc, output int acc_cyc);
    bit ok = 1'b0;
    acc_cyc = -1;
    @(posedge clk);
    #1;
    bus.in_valid    = 1'b1;
    bus.in_elements = el;
    bus.in_scale    = sc;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("accept_timeout", 1, 0);
    end else begin
      acc_cyc = cyc;
      exp_q.push_back('{el: ref_block(el), sc: sc});
      iss_q.push_back(el);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && unit_q.size() == 0 && bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 1, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            t;
    bit            ok;
    blk_el_t       b;
    blk_el_t       snap;
    int            x0;
    int            zi;
    int            exp_idx[7] = '{0, 0, 1, 1, 2, 2, 3};
    blk_el_t       dir_in;
    logic [31:0]   dir_out;

    bus.in_valid    = 1'b0;
    bus.in_elements = '0;
    bus.in_scale    = '0;
    rst             = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_elem_valid", bus.elem_valid, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_err", bus.err_spurious, 0);
    chk("rst_out_elements", bus.out_elements, 0);
    chk("rst_out_scale", bus.out_scale, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", bus.in_ready, 1);

    // Directed block: latency and known negation results.
    dir_in  = {8'h01, 8'h80, 8'h7F, 8'h00};
    dir_out = 32'hFF808100;
    send_block(dir_in, 8'h7F, t);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        ok = 1'b1;
        chk("directed_latency", cyc - t, 7);
        chk("directed_elements", bus.out_elements, dir_out);
        chk("directed_scale", bus.out_scale, 8'h7F);
        break;
      end
    end
    if (!ok) chk("directed_out_timeout", 1, 0);
    wait_idle();

    // Alternating elem_ready starting low.
    ready_mode = 1;
    idx_log.delete();
    log_idx = 1'b1;
    send_block(rand_block(1'b0), 8'($urandom), t);
    wait_idle();
    log_idx = 1'b0;
    chk("idx_log_len", idx_log.size(), 8);
    for (int i = 0; i < 7; i++) begin
      if (i < idx_log.size()) chk("idx_sequence", idx_log[i], exp_idx[i]);
    end
    ready_mode = 0;

    // Output backpressure for 10 cycles.
    @(negedge clk);
    out_rdy_hold = 1'b0;
    send_block(rand_block(1'b0), 8'($urandom), t);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("backpressure_out_timeout", 1, 0);
    x0 = xfer_cnt;
    repeat (10) begin
      @(negedge clk);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
    end
    out_rdy_hold = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_in_ready_after", bus.in_ready, 1);
    chk("bp_out_valid_after", bus.out_valid, 0);
    chk("bp_single_transfer", xfer_cnt - x0, 1);
    wait_idle();

    // Back-to-back random blocks, the last three with one zero element.
    ready_mode   = 2;
    out_rdy_rand = 1'b1;
    for (int n = 0; n < 13; n++) begin
      if (n < 10) begin
        b = rand_block(1'b0);
      end else begin
        b     = rand_block(1'b1);
        zi    = $urandom_range(0, BS - 1);
        b[zi] = '0;
      end
      send_block(b, 8'($urandom), t);
    end
    wait_idle();
    out_rdy_rand = 1'b0;
    out_rdy_hold = 1'b1;
    ready_mode   = 0;
    @(negedge clk);

    // Spurious result while idle.
    chk("err_clear_before_spurious", bus.err_spurious, 0);
    snap     = bus.out_elements;
    spur_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("err_after_idle_spurious", bus.err_spurious, 1);
    chk("out_elements_unchanged", bus.out_elements, snap);
    chk("in_ready_after_spurious", bus.in_ready, 1);

    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("err_cleared_by_rst", bus.err_spurious, 0);

    // Reset in the middle of a block; late results must be flagged.
    send_block(rand_block(1'b0), 8'($urandom), t);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.elem_valid && bus.elem_ready && bus.elem_idx == 2'd2) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("third_issue_timeout", 1, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    iss_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("mid_rst_no_out_valid", bus.out_valid, 0);
    end
    chk("mid_rst_idle", bus.in_ready, 1);
    chk("mid_rst_no_issue", bus.elem_valid, 0);
    chk("mid_rst_err_spurious", bus.err_spurious, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
